// File: rtl/pcr_split_tree_ctrl.sv
// Sequencing controller for a 1-to-8 splitter tree: it routes the inlet to one outlet,
// then settles, meters the volume in pump pulses, flushes, and reports completion.
module pcr_split_tree_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int FLUSH_CYC  = 2,
   parameter int VOL_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_dest,
   input  logic [VOL_W-1:0] req_vol,
   input  logic             abort,
   output logic [6:0]       valve_en,
   output logic [6:0]       valve_sel,
   output logic             pump_en,
   output logic             busy,
   output logic             done,
   output logic [2:0]       done_dest,
   output logic             done_aborted,
   output logic [VOL_W-1:0] disp_cnt
);

   localparam int TMR_MAX = (SETTLE_CYC > FLUSH_CYC) ? SETTLE_CYC : FLUSH_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_FLUSH    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [2:0]       dest_r, dest_s;
   logic [VOL_W-1:0] vol_r, vol_s;
   logic [VOL_W-1:0] pulse_r, pulse_s;
   logic             aborted_r, aborted_s;
   logic [TMR_W-1:0] tmr_r, tmr_s;
   logic             open_s;

   // Heap-ordered path: root (node 1), then node 2+d[2], then node 4+2*d[2]+d[1].
   function automatic logic [6:0] path_en(input logic [2:0] d);
      return 7'd1
           | (7'd1 << (3'd1 + {2'b00, d[2]}))
           | (7'd1 << (3'd3 + {1'b0, d[2], 1'b0} + {2'b00, d[1]}));
   endfunction

   function automatic logic [6:0] path_sel(input logic [2:0] d);
      return {6'd0, d[2]}
           | ({6'd0, d[1]} << (3'd1 + {2'b00, d[2]}))
           | ({6'd0, d[0]} << (3'd3 + {1'b0, d[2], 1'b0} + {2'b00, d[1]}));
   endfunction

   // Next-state, request latching, settle/flush timing and pulse counting.
   always_comb begin
      state_s   = state_r;
      dest_s    = dest_r;
      vol_s     = vol_r;
      pulse_s   = pulse_r;
      aborted_s = aborted_r;
      tmr_s     = tmr_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               dest_s    = req_dest;
               vol_s     = req_vol;
               pulse_s   = '0;
               aborted_s = 1'b0;
               tmr_s     = '0;
               if (req_vol == '0) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_SETTLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               aborted_s = 1'b1;
               tmr_s     = '0;
               state_s   = ST_FLUSH;
            end else if (tmr_r == TMR_W'(SETTLE_CYC - 1)) begin
               tmr_s   = '0;
               state_s = ST_DISPENSE;
            end else begin
               tmr_s = tmr_r + TMR_W'(1);
            end
         end
         ST_DISPENSE: begin
            // The pulse of the current cycle counts even when abort arrives with it.
            pulse_s = pulse_r + VOL_W'(1);
            if (abort) begin
               aborted_s = 1'b1;
               tmr_s     = '0;
               state_s   = ST_FLUSH;
            end else if (pulse_s == vol_r) begin
               tmr_s   = '0;
               state_s = ST_FLUSH;
            end else begin
               state_s = ST_DISPENSE;
            end
         end
         ST_FLUSH: begin
            if (tmr_r == TMR_W'(FLUSH_CYC - 1)) begin
               tmr_s   = '0;
               state_s = ST_DONE;
            end else begin
               tmr_s = tmr_r + TMR_W'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      open_s = (state_s == ST_SETTLE) || (state_s == ST_DISPENSE) || (state_s == ST_FLUSH);
   end

   // State, context and registered outputs derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         dest_r       <= 3'd0;
         vol_r        <= '0;
         pulse_r      <= '0;
         aborted_r    <= 1'b0;
         tmr_r        <= '0;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         valve_en     <= 7'd0;
         valve_sel    <= 7'd0;
         pump_en      <= 1'b0;
         done         <= 1'b0;
         done_dest    <= 3'd0;
         done_aborted <= 1'b0;
         disp_cnt     <= '0;
      end else begin
         state_r      <= state_s;
         dest_r       <= dest_s;
         vol_r        <= vol_s;
         pulse_r      <= pulse_s;
         aborted_r    <= aborted_s;
         tmr_r        <= tmr_s;
         req_ready    <= (state_s == ST_IDLE);
         busy         <= (state_s != ST_IDLE);
         valve_en     <= open_s ? path_en(dest_s) : 7'd0;
         valve_sel    <= open_s ? path_sel(dest_s) : 7'd0;
         pump_en      <= (state_s == ST_DISPENSE);
         done         <= (state_s == ST_DONE);
         done_dest    <= (state_s == ST_DONE) ? dest_s : 3'd0;
         done_aborted <= (state_s == ST_DONE) ? aborted_s : 1'b0;
         disp_cnt     <= (state_s == ST_DONE) ? pulse_s : '0;
      end
   end

endmodule

// File: tb/tb_pcr_split_tree_ctrl.sv
// Bench for pcr_split_tree_ctrl: a request-timeline model predicts every output each cycle,
// with directed scenarios pinned by literal values and a randomized soak.
module tb_pcr_split_tree_ctrl;
   localparam int S  = 4;
   localparam int F  = 2;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst, req_valid, abort;
   logic [2:0]    req_dest;
   logic [VW-1:0] req_vol;
   logic          req_ready, pump_en, busy, done, done_aborted;
   logic [6:0]    valve_en, valve_sel;
   logic [2:0]    done_dest;
   logic [VW-1:0] disp_cnt;

   pcr_split_tree_ctrl #(.SETTLE_CYC(S), .FLUSH_CYC(F), .VOL_W(VW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_dest(req_dest), .req_vol(req_vol), .abort(abort),
      .valve_en(valve_en), .valve_sel(valve_sel), .pump_en(pump_en), .busy(busy),
      .done(done), .done_dest(done_dest), .done_aborted(done_aborted), .disp_cnt(disp_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Model of the request in flight: accept cycle, pump window end, abort flag.
   bit         active = 1'b0;
   bit         m_ab;
   int         m_t0, m_pe, m_end, m_vol;
   logic [2:0] m_dest;

   function automatic int path_mask(input logic [2:0] d, input bit want_sel);
      int k = 1;
      int m = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         int b;
         b = int'(d[2-lvl]);
         if (want_sel) m = m | (b << (k - 1));
         else          m = m | (1 << (k - 1));
         k = 2 * k + b;
      end
      return m;
   endfunction

   function automatic int done_cycle();
      return (m_vol == 0) ? m_t0 + 1 : m_end + F + 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic compare();
      int e_ready, e_busy, e_ven, e_vsel, e_pump, e_done, disp;
      e_ready = 1; e_busy = 0; e_ven = 0; e_vsel = 0; e_pump = 0; e_done = 0;
      disp = (m_end >= m_t0 + 1 + S) ? m_end - (m_t0 + S) : 0;
      if (active) begin
         e_ready = 0;
         e_busy  = 1;
         if (m_vol != 0 && cyc <= m_end + F) begin
            e_ven  = path_mask(m_dest, 1'b0);
            e_vsel = path_mask(m_dest, 1'b1);
         end
         if (m_vol != 0 && cyc >= m_t0 + 1 + S && cyc <= m_end) e_pump = 1;
         if (cyc == done_cycle()) e_done = 1;
      end
      check("req_ready", {31'd0, req_ready}, e_ready);
      check("busy", {31'd0, busy}, e_busy);
      check("valve_en", {25'd0, valve_en}, e_ven);
      check("valve_sel", {25'd0, valve_sel}, e_vsel);
      check("pump_en", {31'd0, pump_en}, e_pump);
      check("done", {31'd0, done}, e_done);
      check("pump_needs_valve", {31'd0, pump_en && (valve_en == 7'd0)}, 0);
      if (e_done == 1) begin
         check("done_dest", {29'd0, done_dest}, {29'd0, m_dest});
         check("done_aborted", {31'd0, done_aborted}, {31'd0, m_ab});
         check("disp_cnt", {24'd0, disp_cnt}, disp);
      end
   endtask

   // Advance the model across the edge ending cycle cyc, take the edge, then compare.
   task automatic step();
      if (rst) begin
         active = 1'b0;
      end else begin
         if (active && !m_ab && m_vol != 0 && abort && cyc >= m_t0 + 1 && cyc <= m_pe) begin
            m_ab  = 1'b1;
            m_end = cyc;
         end
         if (!active && req_valid) begin
            active = 1'b1;
            m_t0   = cyc;
            m_dest = req_dest;
            m_vol  = int'(req_vol);
            m_ab   = 1'b0;
            m_pe   = cyc + S + m_vol;
            m_end  = m_pe;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (active && cyc > done_cycle()) active = 1'b0;
      if (chk_en) compare();
   endtask

   task automatic send(input logic [2:0] d, input logic [VW-1:0] v);
      req_valid = 1'b1;
      req_dest  = d;
      req_vol   = v;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      bit got;
      rst = 1'b1; req_valid = 1'b0; abort = 1'b0; req_dest = 3'd0; req_vol = '0;
      step();
      chk_en = 1'b1;
      step();
      step();
      check("rst_ready", {31'd0, req_ready}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_valve", {25'd0, valve_en}, 0);
      check("rst_done", {31'd0, done}, 0);
      rst = 1'b0;
      step();

      // dest=5, vol=3: nominal timeline
      send(3'd5, 8'd3);
      for (int k = 1; k <= 12; k++) begin
         if (k <= 9) begin
            check("t5_valve_en", {25'd0, valve_en}, 32'h25);
            check("t5_valve_sel", {25'd0, valve_sel}, 32'h21);
         end
         check("t5_pump", {31'd0, pump_en}, (k >= 5 && k <= 7) ? 1 : 0);
         check("t5_done", {31'd0, done}, (k == 10) ? 1 : 0);
         if (k == 10) begin
            check("t5_dest", {29'd0, done_dest}, 5);
            check("t5_disp", {24'd0, disp_cnt}, 3);
            check("t5_abort", {31'd0, done_aborted}, 0);
         end
         step();
      end

      // dest=2, vol=0: immediate completion
      send(3'd2, 8'd0);
      check("v0_done", {31'd0, done}, 1);
      check("v0_disp", {24'd0, disp_cnt}, 0);
      check("v0_valve", {25'd0, valve_en}, 0);
      check("v0_pump", {31'd0, pump_en}, 0);
      step();
      check("v0_ready", {31'd0, req_ready}, 1);
      step();

      // dest=7, vol=10, abort in the 4th pump cycle
      send(3'd7, 8'd10);
      for (int k = 1; k <= 12; k++) begin
         abort = (k == 8);
         if (k == 8) check("ab_pump_on", {31'd0, pump_en}, 1);
         if (k == 9 || k == 10) begin
            check("ab_pump_off", {31'd0, pump_en}, 0);
            check("ab_valve", {25'd0, valve_en}, 32'h45);
         end
         if (k == 11) begin
            check("ab_done", {31'd0, done}, 1);
            check("ab_flag", {31'd0, done_aborted}, 1);
            check("ab_disp", {24'd0, disp_cnt}, 4);
         end
         step();
      end
      abort = 1'b0;

      // back-to-back with req_valid held high
      req_valid = 1'b1; req_dest = 3'd0; req_vol = 8'd1;
      step();
      req_dest = 3'd3;
      for (int k = 1; k <= 9; k++) begin
         check("b2b_ready", {31'd0, req_ready}, (k == 9) ? 1 : 0);
         if (k <= 7) begin
            check("b2b_valve0", {25'd0, valve_en}, 32'h0B);
            check("b2b_sel0", {25'd0, valve_sel}, 0);
         end
         if (k == 8) check("b2b_done1", {31'd0, done}, 1);
         step();
      end
      check("b2b_second_busy", {31'd0, busy}, 1);
      check("b2b_valve3", {25'd0, valve_en}, 32'h13);
      check("b2b_sel3", {25'd0, valve_sel}, 32'h12);
      req_valid = 1'b0;
      for (int n = 0; n < 30 && !req_ready; n++) step();
      check("b2b_idle_again", {31'd0, req_ready}, 1);

      // reset in the 2nd pump cycle
      send(3'd1, 8'd8);
      for (int k = 1; k <= 6; k++) begin
         if (k == 6) begin
            check("rstmid_pump", {31'd0, pump_en}, 1);
            rst = 1'b1;
         end
         step();
      end
      rst = 1'b0;
      check("rstmid_pump_off", {31'd0, pump_en}, 0);
      check("rstmid_valve_off", {25'd0, valve_en}, 0);
      check("rstmid_ready", {31'd0, req_ready}, 1);
      for (int n = 0; n < 12; n++) begin
         check("rstmid_no_done", {31'd0, done}, 0);
         step();
      end
      send(3'd6, 8'd2);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         if (done) begin
            got = 1'b1;
            check("rec_dest", {29'd0, done_dest}, 6);
            check("rec_disp", {24'd0, disp_cnt}, 2);
         end else begin
            step();
         end
      end
      check("rec_done_seen", {31'd0, got}, 1);
      step();

      // randomized soak
      for (int n = 0; n < 2000; n++) begin
         req_valid = ($urandom_range(0, 2) == 0);
         req_dest  = 3'($urandom_range(0, 7));
         req_vol   = VW'($urandom_range(0, 12));
         abort     = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      req_valid = 1'b0; abort = 1'b0; rst = 1'b0;
      repeat (30) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pcr_split_tree_ctrl.md
# pcr_split_tree_ctrl

Sequencing controller for a 1-to-8 binary splitter tree, the distribution counterpart of the PCR mixing tree: it routes a single inlet fluid through three levels of splitter valves to one of eight outlets and meters a dispensed volume in pump pulses. It accepts one dispense request at a time through a valid/ready handshake. For each request it opens the valve path, waits for flow to settle, pumps, flushes, and reports completion. It is the fluidic-control block that feeds reagent outlets ahead of the mixing stages.

## Interface
- SETTLE_CYC, 4, cycles valves are held open with the pump off before dispensing (must be ≥1)
- FLUSH_CYC, 2, cycles valves are held open with the pump off after dispensing (must be ≥1)
- VOL_W, 8, width of the volume field and the delivered-count field
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_dest  in  3  outlet index 0..7
- req_vol  in  VOL_W  dispense volume in pump pulses (one pulse = one cycle of pump_en)
- abort  in  1  terminate the current dispense early
- valve_en  out  7  open-enable per splitter node; bit k-1 = node k (heap order: node 1 is the root, and node k has children 2k and 2k+1)
- valve_sel  out  7  branch select per node; 1 = right child (2k+1); meaningful only where valve_en=1, 0 elsewhere
- pump_en  out  1  inlet pump drive
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- done_dest  out  3  outlet of the completed request; valid when done=1
- done_aborted  out  1  completed request was aborted; valid when done=1
- disp_cnt  out  VOL_W  pump pulses actually delivered for the completed request; valid when done=1

## Operation
- All outputs are registered. Reset value of every output is 0, except req_ready=1. State resets to IDLE.
- States are IDLE, SETTLE, DISPENSE, FLUSH and DONE.
- IDLE: req_ready=1. When req_valid=1 and req_ready=1, the controller latches dest and vol.
  - vol≠0: go to SETTLE.
  - vol=0: go to DONE, with no valves opened and disp_cnt=0.
- Path for dest d[2:0]:
  - node 1, sel=d[2]
  - node 2+d[2], sel=d[1]
  - node 4+2·d[2]+d[1], sel=d[0]
  - Exactly 3 bits of valve_en are set in SETTLE, DISPENSE and FLUSH; all bits are 0 in IDLE and DONE.
- SETTLE: valves are open and pump_en=0 for SETTLE_CYC cycles, then the controller goes to DISPENSE.
- DISPENSE: pump_en=1 for vol cycles. The pulse counter increments once per pump_en cycle. After the last pulse, go to FLUSH.
- FLUSH: valves are open and pump_en=0 for FLUSH_CYC cycles, then go to DONE.
- DONE: held for one cycle with done=1, valves closed, pump_en=0 and req_ready=0. The controller then returns to IDLE.
- abort:
  - Sampled in SETTLE or DISPENSE: the next state is FLUSH, pump_en=0 on the following cycle, and done_aborted is set.
  - Ignored in IDLE, FLUSH and DONE.
  - If abort is sampled in the same cycle as the final pump pulse, that pulse counts, the request is still flagged aborted, and the next state is FLUSH.
- Requests are not accepted while busy; req_ready=0 in every non-IDLE state. req_dest and req_vol are don't-care outside the accept cycle.
- rst asserted in any state returns the controller to IDLE on the next edge. All outputs are forced to reset values, any pending done is discarded, and no done pulse is issued.

## Timing
- The accept edge is T0. For vol=V≠0 with no abort:
  - valves are open from T0+1
  - pump_en=1 during cycles T0+1+SETTLE_CYC … T0+SETTLE_CYC+V
  - done=1 during cycle T0+SETTLE_CYC+V+FLUSH_CYC+1
  - req_ready=1 one cycle after done
- With defaults, latency from accept to done is V+7 cycles. A vol=0 request gives done at T0+1.
- Minimum spacing between back-to-back accepts is latency+1 cycles (the IDLE cycle).
- The pump never runs with valves closed. pump_en=1 implies valve_en≠0 in the same cycle.

## Test plan
- Reset: hold rst for 3 cycles, then check outputs. Required: req_ready=1, all other outputs 0, busy=0.
- dest=5, vol=3 accepted at T0. Required: valve_en=7'h25 and valve_sel=7'h21 from T0+1 through T0+9; pump_en high for exactly cycles T0+5..T0+7; done at T0+10 with done_dest=5, disp_cnt=3, done_aborted=0.
- dest=2, vol=0. Required: done at T0+1 with disp_cnt=0; valve_en and pump_en stay 0 throughout.
- dest=7, vol=10, abort asserted in the 4th pump cycle. Required: pump_en low the next cycle; valve_en=7'h45 held for 2 more cycles; then done with done_aborted=1, disp_cnt=4.
- Back-to-back: req_valid held high with dest=0,vol=1 and then dest=3,vol=1. Required: the second accept occurs exactly one cycle after the first done; dest=0 gives valve_en=7'h0B, valve_sel=0; req_ready=0 throughout the first request.
- rst asserted mid-DISPENSE (dest=1, vol=8, 2nd pump cycle). Required: pump_en=0 and valve_en=0 on the next edge; no done pulse issued; a new request completes normally afterwards.
